// File: rtl/cdc_fast_event_capture_if.sv
// Event handshake bundle between the fast-domain capture block and its consumer.
// The master drives a FIFO head (value + rise mask) with valid; the slave returns ready.
interface cdc_fast_event_capture_if #(
   parameter int unsigned WIDTH = 8
);
   logic             evt_valid;
   logic             evt_ready;
   logic [WIDTH-1:0] evt_data;
   logic [WIDTH-1:0] evt_rise;

   modport master (
      output evt_valid,
      output evt_data,
      output evt_rise,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_data,
      input  evt_rise,
      output evt_ready
   );
endinterface

// File: rtl/cdc_fast_event_capture.sv
// Fast-domain consumer of a per-bit synchronized bus: qualifies each new value by
// stability, derives the rising-bit mask and queues events in a small FWFT FIFO.
module cdc_fast_event_capture #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned STABLE_CYCLES = 3,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic                          fast_clk,
   input  logic                          reset_n,
   input  logic [WIDTH-1:0]              signal_in_fast,
   cdc_fast_event_capture_if.master      evt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          clr_overflow
);

   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_SETTLE = 1'b1;

   logic [0:0]       state_q,    state_d;
   logic [WIDTH-1:0] sample_q,   sample_d;
   logic [WIDTH-1:0] accepted_q, accepted_d;
   logic [CW-1:0]    cnt_q,      cnt_d;
   logic             push_c;
   logic [WIDTH-1:0] push_data_c;
   logic [WIDTH-1:0] push_rise_c;

   // Qualifier state register.
   always_ff @(posedge fast_clk) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         sample_q   <= '0;
         accepted_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         sample_q   <= sample_d;
         accepted_q <= accepted_d;
         cnt_q      <= cnt_d;
      end
   end

   // A candidate must match for STABLE_CYCLES further samples; returning to the
   // accepted value while settling is treated as skew and produces no event.
   always_comb begin
      state_d    = state_q;
      sample_d   = sample_q;
      accepted_d = accepted_q;
      cnt_d      = cnt_q;
      push_c     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (signal_in_fast != accepted_q) begin
               sample_d = signal_in_fast;
               cnt_d    = '0;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (signal_in_fast != sample_q) begin
               if (signal_in_fast == accepted_q) begin
                  state_d = ST_IDLE;
               end else begin
                  sample_d = signal_in_fast;
                  cnt_d    = '0;
               end
            end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
               push_c     = 1'b1;
               accepted_d = sample_q;
               state_d    = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign push_data_c = sample_q;
   assign push_rise_c = sample_q & ~accepted_q;

   logic [WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [WIDTH-1:0] rise_mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             valid_q;
   logic [WIDTH-1:0] head_data_q;
   logic [WIDTH-1:0] head_rise_q;
   logic             overflow_q;

   logic             full_c;
   logic             pop_c;
   logic             wr_en_c;
   logic             drop_c;
   logic [AW-1:0]    rd_ptr_nxt_c;
   logic [LW-1:0]    remain_c;
   logic [LW-1:0]    level_nxt_c;
   logic [WIDTH-1:0] head_data_nxt_c;
   logic [WIDTH-1:0] head_rise_nxt_c;

   assign full_c       = (level_q == LW'(FIFO_DEPTH));
   assign pop_c        = valid_q & evt.evt_ready;
   assign wr_en_c      = push_c & (~full_c | pop_c);
   assign drop_c       = push_c & full_c & ~pop_c;
   assign rd_ptr_nxt_c = pop_c ? rd_ptr_q + AW'(1) : rd_ptr_q;
   assign remain_c     = level_q - LW'(pop_c);
   assign level_nxt_c  = remain_c + LW'(wr_en_c);

   // Registered head: bypass the pushed entry into an otherwise empty FIFO,
   // otherwise read the surviving oldest entry; hold when nothing is stored.
   always_comb begin
      head_data_nxt_c = head_data_q;
      head_rise_nxt_c = head_rise_q;
      if (level_nxt_c != '0) begin
         if (remain_c == '0) begin
            head_data_nxt_c = push_data_c;
            head_rise_nxt_c = push_rise_c;
         end else begin
            head_data_nxt_c = data_mem[rd_ptr_nxt_c];
            head_rise_nxt_c = rise_mem[rd_ptr_nxt_c];
         end
      end
   end

   // Storage array carries no reset; occupancy is tracked by the pointers.
   always_ff @(posedge fast_clk) begin
      if (wr_en_c) begin
         data_mem[wr_ptr_q] <= push_data_c;
         rise_mem[wr_ptr_q] <= push_rise_c;
      end
   end

   always_ff @(posedge fast_clk) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         valid_q     <= 1'b0;
         head_data_q <= '0;
         head_rise_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         if (wr_en_c) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         rd_ptr_q    <= rd_ptr_nxt_c;
         level_q     <= level_nxt_c;
         valid_q     <= (level_nxt_c != '0);
         head_data_q <= head_data_nxt_c;
         head_rise_q <= head_rise_nxt_c;
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop_c) begin
            overflow_q <= 1'b1;
         end else if (clr_overflow) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign evt.evt_valid = valid_q;
   assign evt.evt_data  = head_data_q;
   assign evt.evt_rise  = head_rise_q;
   assign fifo_level    = level_q;
   assign overflow      = overflow_q;

   a_level_bounded : assert property (@(posedge fast_clk) disable iff (!reset_n)
      level_q <= LW'(FIFO_DEPTH));

   a_cnt_bounded : assert property (@(posedge fast_clk) disable iff (!reset_n)
      cnt_q < CW'(STABLE_CYCLES));

   a_valid_tracks_level : assert property (@(posedge fast_clk) disable iff (!reset_n)
      valid_q == (level_q != '0));

endmodule
